panel_input_ctrl: RTL

- Front-panel conditioner placed directly upstream of the pipeline top-level (data_route). Drives its `rst`, `frequency`, `display` and `ram_addr_dispaly` inputs.
- Synchronises and debounces raw board buttons and switches, then turns button presses into single-cycle step events.
- Maintains the RAM-view address counter and the display-mode selector.
- Generates a stretched, active-high CPU reset for the pipeline.
- Runs on the raw board clock (clk1 domain), not the divided CPU clock.

---
 rtl/panel_input_ctrl_if.sv | 25 ++
 rtl/panel_input_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/panel_input_ctrl_if.sv
// Front-panel bundle: raw buttons/switch in, conditioned pipeline controls out.
// master = board/bench side, slave = panel_input_ctrl.
interface panel_input_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              btn_up;
    logic              btn_down;
    logic              btn_mode;
    logic              btn_cpu_rst;
    logic              sw_freq;
    logic [ADDR_W-1:0] ram_addr_display;
    logic [2:0]        display;
    logic              frequency;
    logic              cpu_rst;

    modport master (
        output btn_up, btn_down, btn_mode, btn_cpu_rst, sw_freq,
        input  ram_addr_display, display, frequency, cpu_rst
    );

    modport slave (
        input  btn_up, btn_down, btn_mode, btn_cpu_rst, sw_freq,
        output ram_addr_display, display, frequency, cpu_rst
    );
endinterface

// File: rtl/panel_input_ctrl.sv
// Front-panel conditioner: sync + debounce, step events, RAM-view address, display mode, stretched CPU reset.
// Optional auto-repeat of up/down steps when PANEL_AUTO_REPEAT_EN is defined.
module panel_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_W          = 6,
    parameter int DISP_MODES      = 7,
    parameter int RST_STRETCH     = 16,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    panel_input_ctrl_if.slave pif
);
    localparam int NB     = 5;
    localparam int I_UP   = 0;
    localparam int I_DN   = 1;
    localparam int I_MODE = 2;
    localparam int I_CRST = 3;
    localparam int I_FREQ = 4;
    localparam int CW     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RW     = $clog2(RST_STRETCH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] STRETCH   = RW'(RST_STRETCH);
    localparam logic [2:0]    MODE_LAST = 3'(DISP_MODES - 1);

    if (DEBOUNCE_CYCLES < 2 || DISP_MODES < 2 || DISP_MODES > 8 ||
        RST_STRETCH < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("panel_input_ctrl: parameter out of range");
    end

    logic [NB-1:0]         raw;
    logic [NB-1:0]         sync1_q, sync2_q;
    logic [NB-1:0]         deb_q, deb_d;
    logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]            prev_q, rise_q, rise_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2:0]            disp_q, disp_d;
    logic [RW-1:0]         str_q, str_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  up_step, dn_step;

    assign raw = {pif.sw_freq, pif.btn_cpu_rst, pif.btn_mode, pif.btn_down, pif.btn_up};

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
                else                      cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        rise_d = deb_q[2:0] & ~prev_q;
    end

`ifdef PANEL_AUTO_REPEAT_EN
    localparam int PW = $clog2(2 * REPEAT_CYCLES + 1);
    localparam logic [PW-1:0] REP_FIRST  = PW'(2 * REPEAT_CYCLES);
    localparam logic [PW-1:0] REP_RELOAD = PW'(REPEAT_CYCLES + 1);

    logic [1:0][PW-1:0] rcnt_q, rcnt_d;
    logic [1:0]         rep_q, rep_d;

    // Counter tracks cycles held since the debounced rise; reload spaces later repeats.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_d[i] = deb_q[i] && (rcnt_q[i] == REP_FIRST);
            if (!deb_q[i])    rcnt_d[i] = '0;
            else if (rep_d[i]) rcnt_d[i] = REP_RELOAD;
            else              rcnt_d[i] = rcnt_q[i] + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q <= '0;
            rep_q  <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            rep_q  <= rep_d;
        end
    end

    assign up_step = rise_q[I_UP] | rep_q[I_UP];
    assign dn_step = rise_q[I_DN] | rep_q[I_DN];
`else
    assign up_step = rise_q[I_UP];
    assign dn_step = rise_q[I_DN];
`endif

    always_comb begin
        case ({up_step, dn_step})
            2'b10:   addr_d = addr_q + ADDR_W'(1);
            2'b01:   addr_d = addr_q - ADDR_W'(1);
            default: addr_d = addr_q;
        endcase
        disp_d = disp_q;
        if (rise_q[I_MODE]) disp_d = (disp_q == MODE_LAST) ? 3'd0 : disp_q + 3'd1;
        if (deb_q[I_CRST])      str_d = STRETCH;
        else if (str_q != '0)   str_d = str_q - RW'(1);
        else                    str_d = '0;
        cpu_rst_d = deb_q[I_CRST] | (str_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            prev_q    <= '0;
            rise_q    <= '0;
            addr_q    <= '0;
            disp_q    <= '0;
            // Board reset behaves like a just-released reset button: the stretch still runs.
            str_q     <= STRETCH;
            cpu_rst_q <= 1'b1;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            prev_q    <= deb_q[2:0];
            rise_q    <= rise_d;
            addr_q    <= addr_d;
            disp_q    <= disp_d;
            str_q     <= str_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign pif.ram_addr_display = addr_q;
    assign pif.display          = disp_q;
    assign pif.frequency        = deb_q[I_FREQ];
    assign pif.cpu_rst          = cpu_rst_q;
endmodule
